// File: rtl/nn_pool_pkg.sv
// Shared types and helpers for the max-pooling stage: FSM state encoding,
// the signed pixel type and the pooled-output dimension helper.
package nn_pool_pkg;

  localparam int PixelWidth = 8;

  typedef logic signed [PixelWidth-1:0] pixel_t;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    DRAIN,
    WRITE,
    DONE
  } pool_state_e;

  // Floor division: partial edge windows are dropped.
  function automatic int pool_out_dim(input int in_dim, input int p);
    return in_dim / p;
  endfunction

endpackage

// File: rtl/pool_addr_gen.sv
// Window/output-pixel counters for the max-pooling stage and the derived
// source (conv map) and destination (pooled map) addresses.
module pool_addr_gen
  import nn_pool_pkg::*;
#(
  parameter int DataSizeW = 28,
  parameter int DataSizeH = 28,
  parameter int PoolSize  = 2,
  parameter int AddrWidth = $clog2(DataSizeW * DataSizeH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 step,
  input  logic                 clear,
  output logic [AddrWidth-1:0] src_addr,
  output logic [AddrWidth-1:0] dst_addr,
  output logic                 last_in_window,
  output logic                 last_pixel
);

  localparam int OutW = pool_out_dim(DataSizeW, PoolSize);
  localparam int OutH = pool_out_dim(DataSizeH, PoolSize);
  localparam int WideW = AddrWidth + 1;

  typedef logic [WideW-1:0] wide_t;

  localparam wide_t One     = wide_t'(1);
  localparam wide_t WinLast = wide_t'(PoolSize - 1);
  localparam wide_t OxLast  = wide_t'(OutW - 1);
  localparam wide_t OyLast  = wide_t'(OutH - 1);

  wide_t wx, wy, ox, oy;
  wide_t src_wide, dst_wide;

  assign last_in_window = (wx == WinLast) && (wy == WinLast);
  assign last_pixel     = (ox == OxLast) && (oy == OyLast);

  // One guard bit keeps the row*width product from wrapping before truncation.
  always_comb begin
    src_wide = (oy * wide_t'(PoolSize) + wy) * wide_t'(DataSizeW)
             + ox * wide_t'(PoolSize) + wx;
    dst_wide = oy * wide_t'(OutW) + ox;
  end

  assign src_addr = src_wide[AddrWidth-1:0];
  assign dst_addr = dst_wide[AddrWidth-1:0];

  // Odometer: wx fastest, then wy, then ox, then oy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wx <= '0;
      wy <= '0;
      ox <= '0;
      oy <= '0;
    end else if (clear) begin
      wx <= '0;
      wy <= '0;
      ox <= '0;
      oy <= '0;
    end else if (step) begin
      if (wx != WinLast) begin
        wx <= wx + One;
      end else begin
        wx <= '0;
        if (wy != WinLast) begin
          wy <= wy + One;
        end else begin
          wy <= '0;
          if (ox != OxLast) begin
            ox <= ox + One;
          end else begin
            ox <= '0;
            oy <= (oy != OyLast) ? oy + One : '0;
          end
        end
      end
    end
  end

endmodule

// File: rtl/maxpool_2d_stage.sv
// Non-overlapping signed PoolSize x PoolSize max-pooling over a BRAM-resident map,
// started/finished by 4-phase req/ack. Define MAXPOOL_RELU_EN to clamp negative maxima to 0.
module maxpool_2d_stage
  import nn_pool_pkg::*;
#(
  parameter int DataSizeW = 28,
  parameter int DataSizeH = 28,
  parameter int PoolSize  = 2,
  parameter int DataWidth = 8,
  parameter int AddrWidth = $clog2(DataSizeW * DataSizeH)
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 req_i,
  output logic                 ack_o,
  output logic                 req_o,
  input  logic                 ack_i,
  output logic [AddrWidth-1:0] src_ram_addr,
  input  logic [DataWidth-1:0] src_ram_dout,
  output logic                 dst_ram_we,
  output logic [AddrWidth-1:0] dst_ram_addr,
  output logic [DataWidth-1:0] dst_ram_din
);

  pool_state_e state;

  logic                        start, step, last_in_window, last_pixel;
  logic                        rd_valid, rd_first;
  logic [AddrWidth-1:0]        dst_addr;
  logic signed [DataWidth-1:0] dout_s, acc, acc_next, pooled;

  assign start  = (state == IDLE) && req_i && !ack_o;
  // The final WRITE does not step, so src_ram_addr keeps showing the last read address.
  assign step   = ((state == READ) && !last_in_window) || ((state == WRITE) && !last_pixel);
  assign dout_s = src_ram_dout;

  pool_addr_gen #(
    .DataSizeW(DataSizeW),
    .DataSizeH(DataSizeH),
    .PoolSize (PoolSize),
    .AddrWidth(AddrWidth)
  ) u_addr_gen (
    .clk           (clk_i),
    .rst           (reset_i),
    .step          (step),
    .clear         (start),
    .src_addr      (src_ram_addr),
    .dst_addr      (dst_addr),
    .last_in_window(last_in_window),
    .last_pixel    (last_pixel)
  );

  // NOTE: default assignment first so every path assigns acc_next and no latch is inferred.
  always_comb begin
    acc_next = acc;
    if (rd_valid && (rd_first || (dout_s > acc))) acc_next = dout_s;
  end

`ifdef MAXPOOL_RELU_EN
  assign pooled = acc_next[DataWidth-1] ? '0 : acc_next;
`else
  assign pooled = acc_next;
`endif

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state        <= IDLE;
      ack_o        <= 1'b0;
      req_o        <= 1'b0;
      dst_ram_we   <= 1'b0;
      dst_ram_addr <= '0;
      dst_ram_din  <= '0;
      acc          <= '0;
      rd_valid     <= 1'b0;
      rd_first     <= 1'b0;
    end else begin
      // NOTE: non-blocking throughout; the strobe defaults low so only the DRAIN branch can raise it.
      dst_ram_we <= 1'b0;
      acc        <= acc_next;
      // Read data trails its address by one cycle; the first READ cycle follows a non-READ cycle.
      rd_valid   <= (state == READ);
      rd_first   <= (state == READ) && !rd_valid;
      if (ack_o && !req_i) ack_o <= 1'b0;

      case (state)
        IDLE: begin
          if (start) begin
            ack_o <= 1'b1;
            state <= READ;
          end
        end
        READ: begin
          if (last_in_window) state <= DRAIN;
        end
        DRAIN: begin
          dst_ram_we   <= 1'b1;
          dst_ram_addr <= dst_addr;
          dst_ram_din  <= pooled;
          state        <= WRITE;
        end
        WRITE: begin
          state <= last_pixel ? DONE : READ;
        end
        DONE: begin
          if (!req_o) begin
            req_o <= 1'b1;
          end else if (ack_i) begin
            req_o <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_maxpool_2d_stage.sv
// Scoreboard bench for maxpool_2d_stage: 4x4, 5x5 and 28x28 instances with behavioural
// source RAMs; expected writes are queued by the stimulus and popped by per-instance monitors.
module tb_maxpool_2d_stage;
  import nn_pool_pkg::*;

  typedef struct {
    logic [9:0] addr;
    logic [7:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // ---------------- 4x4 instance ----------------
  logic       a_req_i = 0, a_ack_i = 0, a_ack, a_req, a_we;
  logic [3:0] a_src, a_dst;
  logic [7:0] a_dout, a_din;
  logic [7:0] a_mem [16];
  wr_t        a_q[$];
  int         a_wr_cnt = 0;

  maxpool_2d_stage #(.DataSizeW(4), .DataSizeH(4), .PoolSize(2), .DataWidth(8)) u_a (
    .clk_i(clk), .reset_i(rst), .req_i(a_req_i), .ack_o(a_ack), .req_o(a_req), .ack_i(a_ack_i),
    .src_ram_addr(a_src), .src_ram_dout(a_dout), .dst_ram_we(a_we), .dst_ram_addr(a_dst),
    .dst_ram_din(a_din));

  always @(posedge clk) a_dout <= a_mem[a_src];

  always @(negedge clk) begin
    wr_t e;
    if (a_we === 1'b1) begin
      check("a_write_expected", (a_q.size() > 0), 1);
      if (a_q.size() > 0) begin
        e = a_q.pop_front();
        check("a_wr_addr", a_dst, e.addr);
        check("a_wr_data", a_din, e.data);
      end
      a_wr_cnt++;
    end
  end

  // ---------------- 5x5 instance ----------------
  logic       b_req_i = 0, b_ack_i = 0, b_ack, b_req, b_we;
  logic [4:0] b_src, b_dst;
  logic [7:0] b_dout, b_din;
  logic [7:0] b_mem [25];
  wr_t        b_q[$];
  int         b_wr_cnt = 0;
  int         b_viol = 0;

  maxpool_2d_stage #(.DataSizeW(5), .DataSizeH(5), .PoolSize(2), .DataWidth(8)) u_b (
    .clk_i(clk), .reset_i(rst), .req_i(b_req_i), .ack_o(b_ack), .req_o(b_req), .ack_i(b_ack_i),
    .src_ram_addr(b_src), .src_ram_dout(b_dout), .dst_ram_we(b_we), .dst_ram_addr(b_dst),
    .dst_ram_din(b_din));

  always @(posedge clk) b_dout <= (b_src < 5'd25) ? b_mem[b_src] : 8'h00;

  // Row 4 and column 4 belong only to partial windows.
  always @(negedge clk) if ((b_src % 5 == 4) || (b_src >= 5'd20)) b_viol++;

  always @(negedge clk) begin
    wr_t e;
    if (b_we === 1'b1) begin
      check("b_write_expected", (b_q.size() > 0), 1);
      if (b_q.size() > 0) begin
        e = b_q.pop_front();
        check("b_wr_addr", b_dst, e.addr);
        check("b_wr_data", b_din, e.data);
      end
      b_wr_cnt++;
    end
  end

  // ---------------- 28x28 instance ----------------
  logic       c_req_i = 0, c_ack_i = 0, c_ack, c_req, c_we;
  logic [9:0] c_src, c_dst;
  logic [7:0] c_dout, c_din;
  logic [7:0] c_mem [784];
  wr_t        c_q[$];
  wr_t        c_exp[196];
  int         c_wr_cnt = 0;

  maxpool_2d_stage #(.DataSizeW(28), .DataSizeH(28), .PoolSize(2), .DataWidth(8)) u_c (
    .clk_i(clk), .reset_i(rst), .req_i(c_req_i), .ack_o(c_ack), .req_o(c_req), .ack_i(c_ack_i),
    .src_ram_addr(c_src), .src_ram_dout(c_dout), .dst_ram_we(c_we), .dst_ram_addr(c_dst),
    .dst_ram_din(c_din));

  always @(posedge clk) c_dout <= (c_src < 10'd784) ? c_mem[c_src] : 8'h00;

  always @(negedge clk) begin
    wr_t e;
    if (c_we === 1'b1) begin
      check("c_write_expected", (c_q.size() > 0), 1);
      if (c_q.size() > 0) begin
        e = c_q.pop_front();
        check("c_wr_addr", c_dst, e.addr);
        check("c_wr_data", c_din, e.data);
      end
      c_wr_cnt++;
    end
  end

  // ---------------- helpers ----------------
  function automatic logic sig_val(input int sel);
    case (sel)
      0: return a_ack;
      1: return a_req;
      2: return b_ack;
      3: return b_req;
      4: return c_ack;
      5: return c_req;
      default: return 1'b0;
    endcase
  endfunction

  task automatic wait_level(input string name, input int sel, input logic val,
                            input int budget, output int at_cyc);
    int n = 0;
    while (sig_val(sel) !== val && n < budget) begin
      @(negedge clk);
      n++;
    end
    at_cyc = cyc;
    if (sig_val(sel) !== val) check({name, "_timeout"}, sig_val(sel), val);
  endtask

  function automatic logic [7:0] relu(input logic [7:0] v);
`ifdef MAXPOOL_RELU_EN
    return v[7] ? 8'h00 : v;
`else
    return v;
`endif
  endfunction

  function automatic wr_t mk(input int addr, input logic [7:0] data);
    wr_t w;
    w.addr = 10'(addr);
    w.data = data;
    return w;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int t_ack, t_done, t_tmp, base_cnt, hit;
  pixel_t m, v;

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 16; i++) a_mem[i] = 8'(i);
    for (int i = 0; i < 25; i++) b_mem[i] = 8'(i);
    for (int i = 0; i < 784; i++) c_mem[i] = 8'($urandom_range(0, 255));

    // Reset state
    @(negedge clk);
    check("rst_ack_o", a_ack, 0);
    check("rst_req_o", a_req, 0);
    check("rst_we", a_we, 0);
    check("rst_src_addr", a_src, 0);
    check("rst_dst_addr", a_dst, 0);
    check("rst_dst_din", a_din, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // 4x4 ramp, req_i held high all run, ack_i held low 10 cycles in DONE
    a_q.push_back(mk(0, 8'd5));
    a_q.push_back(mk(1, 8'd7));
    a_q.push_back(mk(2, 8'd13));
    a_q.push_back(mk(3, 8'd15));
    a_req_i = 1'b1;
    wait_level("t1_ack", 0, 1'b1, 10, t_ack);
    wait_level("t1_done", 1, 1'b1, 200, t_done);
    check("t1_latency", t_done - t_ack, 25);
    check("t1_ack_held", a_ack, 1);
    check("t1_src_hold_last", a_src, 15);
    base_cnt = a_wr_cnt;
    repeat (10) begin
      @(negedge clk);
      check("t1_req_hold", a_req, 1);
    end
    check("t1_no_write_in_done", a_wr_cnt, base_cnt);
    a_ack_i = 1'b1;
    @(negedge clk);
    check("t1_req_drop", a_req, 0);
    a_ack_i = 1'b0;
    repeat (10) begin
      @(negedge clk);
      check("t1_no_restart_req", a_req, 0);
    end
    check("t1_ack_still_high", a_ack, 1);
    check("t1_no_second_run", a_wr_cnt, base_cnt);
    a_req_i = 1'b0;
    @(negedge clk);
    check("t1_ack_clear", a_ack, 0);
    check("t1_queue_empty", a_q.size(), 0);

    // 4x4 signed windows, req_i dropped mid-run, ack_i already high in DONE
    a_mem[0]  = 8'hFF; a_mem[1]  = 8'hFB; a_mem[4]  = 8'hFD; a_mem[5]  = 8'hFE;
    a_mem[2]  = 8'h80; a_mem[3]  = 8'h7F; a_mem[6]  = 8'h00; a_mem[7]  = 8'h01;
    a_mem[8]  = 8'hF9; a_mem[9]  = 8'hF8; a_mem[12] = 8'hF7; a_mem[13] = 8'hF6;
    a_mem[10] = 8'h03; a_mem[11] = 8'hFC; a_mem[14] = 8'h64; a_mem[15] = 8'h9C;
`ifdef MAXPOOL_RELU_EN
    a_q.push_back(mk(0, 8'h00));
    a_q.push_back(mk(1, 8'h7F));
    a_q.push_back(mk(2, 8'h00));
    a_q.push_back(mk(3, 8'h64));
`else
    a_q.push_back(mk(0, 8'hFF));
    a_q.push_back(mk(1, 8'h7F));
    a_q.push_back(mk(2, 8'hF9));
    a_q.push_back(mk(3, 8'h64));
`endif
    a_req_i = 1'b1;
    wait_level("t2_ack", 0, 1'b1, 10, t_ack);
    a_req_i = 1'b0;
    @(negedge clk);
    check("t2_ack_clears_midrun", a_ack, 0);
    a_ack_i = 1'b1;
    wait_level("t2_done", 1, 1'b1, 200, t_done);
    check("t2_latency", t_done - t_ack, 25);
    @(negedge clk);
    check("t2_req_one_cycle", a_req, 0);
    a_ack_i = 1'b0;
    check("t2_queue_empty", a_q.size(), 0);

    // 5x5: partial edge windows skipped
    b_q.push_back(mk(0, 8'd6));
    b_q.push_back(mk(1, 8'd8));
    b_q.push_back(mk(2, 8'd16));
    b_q.push_back(mk(3, 8'd18));
    b_req_i = 1'b1;
    wait_level("t3_ack", 2, 1'b1, 10, t_ack);
    b_req_i = 1'b0;
    wait_level("t3_done", 3, 1'b1, 200, t_done);
    check("t3_latency", t_done - t_ack, 25);
    b_ack_i = 1'b1;
    wait_level("t3_req_drop", 3, 1'b0, 5, t_tmp);
    b_ack_i = 1'b0;
    check("t3_write_count", b_wr_cnt, 4);
    check("t3_edge_reads", b_viol, 0);
    check("t3_queue_empty", b_q.size(), 0);

    // 28x28 reference model
    for (int oy = 0; oy < 14; oy++) begin
      for (int ox = 0; ox < 14; ox++) begin
        m = pixel_t'(c_mem[(oy * 2) * 28 + ox * 2]);
        for (int wy = 0; wy < 2; wy++) begin
          for (int wx = 0; wx < 2; wx++) begin
            v = pixel_t'(c_mem[(oy * 2 + wy) * 28 + ox * 2 + wx]);
            if (v > m) m = v;
          end
        end
        c_exp[oy * 14 + ox] = mk(oy * 14 + ox, relu(8'(m)));
      end
    end

    // 28x28 run interrupted by reset during the 2nd WRITE
    c_q.push_back(c_exp[0]);
    c_q.push_back(c_exp[1]);
    c_req_i = 1'b1;
    wait_level("t4_ack", 4, 1'b1, 10, t_ack);
    hit = 0;
    for (int n = 0; n < 100 && hit == 0; n++) begin
      @(negedge clk);
      #1;
      if (c_wr_cnt == 2) hit = 1;
    end
    check("t4_second_write_seen", hit, 1);
    check("t4_in_write", c_we, 1);
    rst = 1'b1;
    c_req_i = 1'b0;
    #1;
    check("t4_async_we", c_we, 0);
    check("t4_async_ack", c_ack, 0);
    check("t4_async_req", c_req, 0);
    check("t4_async_src", c_src, 0);
    check("t4_async_dst", c_dst, 0);
    check("t4_async_din", c_din, 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("t4_queue_empty", c_q.size(), 0);
    repeat (5) @(negedge clk);
    check("t4_idle_after_reset", c_wr_cnt, 2);
    check("t4_idle_src", c_src, 0);

    // Fresh full 28x28 run
    for (int i = 0; i < 196; i++) c_q.push_back(c_exp[i]);
    base_cnt = c_wr_cnt;
    c_req_i = 1'b1;
    wait_level("t5_ack", 4, 1'b1, 10, t_ack);
    c_req_i = 1'b0;
    wait_level("t5_done", 5, 1'b1, 2000, t_done);
    check("t5_latency", t_done - t_ack, 1177);
    c_ack_i = 1'b1;
    wait_level("t5_req_drop", 5, 1'b0, 5, t_tmp);
    c_ack_i = 1'b0;
    check("t5_write_count", c_wr_cnt - base_cnt, 196);
    check("t5_queue_empty", c_q.size(), 0);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
